// File: rtl/riscv32_pkg.sv
// ----------------------------------------------------------------------------
// riscv32_pkg
//
// Purpose:
//   Shared constants for the RV32 core memory subsystem, as used by the data
//   RAM arbiter and its round-robin picker.
//
// Contents:
//   ARB_IDLE / ARB_ACCESS / ARB_RESP   arbiter state encodings
//   REQ_LSU / REQ_AMO / REQ_DBG        requester slot indices
//   RAM_AW / RAM_DW                    data RAM address / data widths
//   onehot_any()                       helper: any bit of a request vector
// ----------------------------------------------------------------------------
package riscv32_pkg;

    // Arbiter state encodings
    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_ACCESS = 2'd1;
    localparam logic [1:0] ARB_RESP   = 2'd2;

    // Requester slot assignment on the arbiter
    localparam int REQ_LSU = 0;
    localparam int REQ_AMO = 1;
    localparam int REQ_DBG = 2;

    // Data RAM geometry
    localparam int RAM_AW = 8;
    localparam int RAM_DW = 32;

    // Reduction helper kept here so callers read as intent, not as operators.
    function automatic logic onehot_any(input logic [7:0] vec);
        return |vec;
    endfunction

endpackage

// File: rtl/ram_arb_rr_pick.sv
// ----------------------------------------------------------------------------
// ram_arb_rr_pick
//
// Purpose:
//   Purely combinational round-robin picker. Scans the request vector
//   starting at the priority pointer and wrapping around, and reports the
//   first set request it finds.
//
// Ports:
//   req   in   NREQ  request vector (already masked by any ownership logic)
//   ptr   in   PW    index that has highest priority this round
//   gnt   out  NREQ  one-hot winner (all zero if no request)
//   idx   out  PW    encoded winner index (0 if no request)
//   any   out  1     at least one request present
// ----------------------------------------------------------------------------
module ram_arb_rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx,
    output logic            any
);

    always_comb begin
        int k;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = 0;
        for (int i = 0; i < NREQ; i++) begin
            // Rotate the scan so position 0 of the scan is the pointer.
            k = int'(ptr) + i;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = k[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
//
// Purpose:
//   Round-robin arbiter sharing the single-port data RAM (one-cycle
//   synchronous read) between NREQ requesters: 0 = LSU, 1 = AMO/FPU memory,
//   2 = debug/loader. Each access is IDLE -> ACCESS (-> RESP for reads).
//   Writes take 2 cycles per access, reads 3.
//
// Configuration:
//   RAM_ARB_LOCK_EN  when defined, a grant with iLOCK=1 keeps ownership with
//                    that requester until one of its grants has iLOCK=0, so
//                    read-modify-write pairs are indivisible. When undefined
//                    iLOCK is ignored and arbitration is pure round-robin.
//
// Ports:
//   iCLK        in   1        clock, rising edge
//   iRST_N      in   1        asynchronous active-low reset
//   iREQ        in   NREQ     level request, held until oGNT
//   iWE         in   NREQ     1 = write, 0 = read
//   iLOCK       in   NREQ     keep ownership after this access
//   iADDR       in   NREQ*AW  packed addresses, slot k at [k*AW +: AW]
//   iWDATA      in   NREQ*DW  packed write data, slot k at [k*DW +: DW]
//   oGNT        out  NREQ     one-hot pulse, command consumed (ACCESS cycle)
//   oRVALID     out  NREQ     one-hot pulse, oRDATA valid (RESP cycle)
//   oRDATA      out  DW       read data, zero outside RESP
//   oRAM_CE     out  1        RAM chip enable
//   oRAM_RD     out  1        RAM read strobe
//   oRAM_WR     out  1        RAM write strobe
//   oRAM_ADDR   out  AW       RAM address, zero outside ACCESS
//   oRAM_DATA   out  DW       RAM write data, zero outside write ACCESS
//   iRAM_DATA   in   DW       RAM read data, valid the cycle after oRAM_RD
// ----------------------------------------------------------------------------
module ram_arbiter
    import riscv32_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = RAM_AW,
    parameter int DW   = RAM_DW
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [NREQ-1:0]   iREQ,
    input  logic [NREQ-1:0]   iWE,
    input  logic [NREQ-1:0]   iLOCK,
    input  logic [NREQ*AW-1:0] iADDR,
    input  logic [NREQ*DW-1:0] iWDATA,
    output logic [NREQ-1:0]   oGNT,
    output logic [NREQ-1:0]   oRVALID,
    output logic [DW-1:0]     oRDATA,
    output logic              oRAM_CE,
    output logic              oRAM_RD,
    output logic              oRAM_WR,
    output logic [AW-1:0]     oRAM_ADDR,
    output logic [DW-1:0]     oRAM_DATA,
    input  logic [DW-1:0]     iRAM_DATA
);

    localparam int            PW   = $clog2(NREQ);
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE   = ARB_IDLE,
        S_ACCESS = ARB_ACCESS,
        S_RESP   = ARB_RESP
    } state_t;

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [NREQ-1:0]   cur_gnt;   // winner of the access in flight
    logic              cur_we;    // access in flight is a write

    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   rvalid_q;
    logic              ram_ce_q;
    logic              ram_rd_q;
    logic              ram_wr_q;
    logic [AW-1:0]     ram_addr_q;
    logic [DW-1:0]     ram_data_q;

    logic [NREQ-1:0]   req_eff;
    logic [NREQ-1:0]   pick_gnt;
    logic [PW-1:0]     pick_idx;
    logic              pick_any;
    logic [PW-1:0]     ptr_next;

`ifdef RAM_ARB_LOCK_EN
    logic              locked;
    logic [PW-1:0]     owner;

    // While locked only the owner may win; everyone else stalls in IDLE.
    always_comb begin
        req_eff = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_eff[k] = iREQ[k] & (!locked || (owner == PW'(k)));
        end
    end
`else
    logic unused_lock;

    assign unused_lock = ^iLOCK;
    assign req_eff     = iREQ;
`endif

    ram_arb_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req  (req_eff),
        .ptr  (ptr),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Winner + 1, wrapping NREQ-1 back to 0 for non-power-of-two NREQ.
    assign ptr_next = (pick_idx == LAST) ? '0 : pick_idx + 1'b1;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= S_IDLE;
            ptr        <= '0;
            cur_gnt    <= '0;
            cur_we     <= 1'b0;
            gnt_q      <= '0;
            rvalid_q   <= '0;
            ram_ce_q   <= 1'b0;
            ram_rd_q   <= 1'b0;
            ram_wr_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
`ifdef RAM_ARB_LOCK_EN
            locked     <= 1'b0;
            owner      <= '0;
`endif
        end else begin
            // Pulses and RAM pins default low; only the transition into
            // ACCESS / RESP raises them for exactly one cycle.
            gnt_q      <= '0;
            rvalid_q   <= '0;
            ram_ce_q   <= 1'b0;
            ram_rd_q   <= 1'b0;
            ram_wr_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;

            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        cur_gnt    <= pick_gnt;
                        cur_we     <= iWE[pick_idx];
                        gnt_q      <= pick_gnt;
                        ram_ce_q   <= 1'b1;
                        ram_wr_q   <= iWE[pick_idx];
                        ram_rd_q   <= ~iWE[pick_idx];
                        ram_addr_q <= iADDR[pick_idx*AW +: AW];
                        ram_data_q <= iWE[pick_idx] ? iWDATA[pick_idx*DW +: DW] : '0;
                        state      <= S_ACCESS;
`ifdef RAM_ARB_LOCK_EN
                        // A locking grant freezes the pointer on the owner;
                        // the unlocking grant resumes normal rotation.
                        if (iLOCK[pick_idx]) begin
                            locked <= 1'b1;
                            owner  <= pick_idx;
                        end else begin
                            locked <= 1'b0;
                            ptr    <= ptr_next;
                        end
`else
                        ptr        <= ptr_next;
`endif
                    end
                end

                S_ACCESS: begin
                    if (cur_we) begin
                        state    <= S_IDLE;
                    end else begin
                        rvalid_q <= cur_gnt;
                        state    <= S_RESP;
                    end
                end

                S_RESP: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign oGNT      = gnt_q;
    assign oRVALID   = rvalid_q;
    // RAM read data arrives during RESP; gate it so the bus is 0 otherwise.
    assign oRDATA    = (|rvalid_q) ? iRAM_DATA : '0;
    assign oRAM_CE   = ram_ce_q;
    assign oRAM_RD   = ram_rd_q;
    assign oRAM_WR   = ram_wr_q;
    assign oRAM_ADDR = ram_addr_q;
    assign oRAM_DATA = ram_data_q;

endmodule
